seq_addsub_ctrl: RTL and testbench
==================================

// Module: seq_addsub_ctrl
// PURPOSE
//  Multi-cycle WIDTH-bit add/subtract sequencer. Time-shares one 8-bit ripple-carry
//  slice with overflow (rca_8_overflow) across WIDTH/8 cycles, LSB byte first.
//  It chains the carry through a register between cycles.
//  Sits in the ALU as the area-reduced adder path, with valid/ready on input and output.
// PARAMETERS
//  WIDTH   32   operand/result width; must be a multiple of 8 and >= 8
//  NBYTES  WIDTH/8 (localparam)   number of slice passes per operation
// PORTS
//  clock         in   1      single clock, rising edge
//  reset         in   1      synchronous, active-high
//  in_valid      in   1      operation request
//  in_ready      out  1      block can accept; 1 only in IDLE
//  a             in   WIDTH  operand A
//  b             in   WIDTH  operand B
//  sub           in   1      0: A+B, 1: A-B
//  out_valid     out  1      result held valid
//  out_ready     in   1      consumer accepts result
//  sum           out  WIDTH  result
//  cout          out  1      carry out of MSB (sub: 1 = no borrow)
//  overflow      out  1      signed overflow = carry into MSB xor carry out of MSB
//  busy          out  1      1 in RUN or DONE
// BEHAVIOUR
//  - FSM states IDLE, RUN, DONE. Reset (sync) -> IDLE. Registered outputs: out_valid=0,
//    sum=0, cout=0, overflow=0, byte index=0, carry reg=0. Decoded outputs in IDLE:
//    in_ready=1, busy=0.
//  - IDLE: in_valid & in_ready -> latch a, (sub ? ~b : b), carry reg <= sub, idx <= 0 -> RUN.
//  - RUN: the slice sees a_lat[8*idx+:8], b_lat[8*idx+:8], and cin = carry reg.
//    Per edge: sum[8*idx+:8] <= slice sum, carry reg <= slice cout, idx <= idx+1.
//  - At idx==NBYTES-1: also cout <= slice cout, overflow <= slice of, out_valid <= 1 -> DONE.
//  - Latency: out_valid rises exactly NBYTES cycles after the accept edge (4 for WIDTH=32).
//  - DONE: out_valid, sum, cout, overflow stable until out_valid & out_ready.
//    On that edge: out_valid <= 0 -> IDLE. No accept in DONE; in_ready=0.
//    Min issue interval = NBYTES+2 cycles.
//  - in_valid while not IDLE: ignored, no state change; a/b/sub changes have no effect.
//  - sum upper bytes not yet computed hold the previous result's bytes during RUN (don't-care).
//    Only the value at out_valid is defined.
//  - reset in RUN or DONE: next edge -> IDLE, all registered outputs cleared, operation dropped.
//  - idx width = clog2(NBYTES), min 1; NBYTES==1 -> single RUN cycle; idx never wraps past NBYTES-1.
// CONFIGURATION
//  Macro SEQ_ADDSUB_CMP_EN:
//  - defined: adds outputs is_not_equal (1) and is_less_than (1), registered with cout/overflow.
//    When sub=1: is_not_equal = |sum, is_less_than = sum[WIDTH-1] ^ overflow (signed A<B).
//    When sub=0: both 0. Reset value 0. Held through DONE like sum.
//  - undefined: ports and logic absent; all other behaviour identical.
// TESTING (WIDTH=32)
//  1. add 0x000000FF + 0x00000001 -> sum 0x00000100, cout 0, overflow 0.
//     out_valid exactly 4 cycles after accept.
//  2. sub 0x80000000 - 0x00000001 -> sum 0x7FFFFFFF, cout 1, overflow 1.
//  3. add 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, cout 0, overflow 1.
//     add 0xFFFFFFFF + 1 -> 0x0, cout 1, overflow 0.
//  4. Hold out_ready=0 for 5 cycles after out_valid; drive new in_valid with a/b toggling
//     -> sum/flags/out_valid stable, in_ready 0. Release -> IDLE next cycle; next op correct.
//  5. Assert reset 1 cycle at idx=2 of RUN -> next cycle in_ready 1, busy 0, out_valid 0, sum 0.
//     Then 0x12345678 + 0x11111111 -> 0x23456789.
//  6. SEQ_ADDSUB_CMP_EN defined:
//     sub 5-7 -> is_less_than 1, is_not_equal 1.
//     sub 7-7 -> 0/0.
//     sub 0x80000000-1 -> is_less_than 1.
//     add 5+7 -> 0/0.

Source files
------------

// File: rtl/seq_addsub_ctrl.sv
// Multi-cycle add/subtract that reuses one 8-bit ripple-carry slice, LSB byte first.
// Optional macro SEQ_ADDSUB_CMP_EN adds the is_not_equal / is_less_than compare outputs.

// rca_8_overflow: 8-bit ripple-carry adder with carry-in, carry-out and signed overflow.
// Latency: combinational.
// Backpressure: none (pure datapath).
module rca_8_overflow (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       overflow
);
    logic [8:0] c;

    always_comb begin
        c    = 9'b0;
        sum  = 8'b0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[8];
    assign overflow = c[8] ^ c[7];
endmodule

// seq_addsub_ctrl: WIDTH-bit A+B / A-B computed one byte per cycle through a shared slice.
// Latency: out_valid rises WIDTH/8 cycles after the accept edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module seq_addsub_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
`ifdef SEQ_ADDSUB_CMP_EN
    output logic             is_not_equal,
    output logic             is_less_than,
`endif
    output logic             busy
);
    localparam int NBYTES = WIDTH / 8;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx;
    logic             carry_q;
    logic [WIDTH-1:0] a_lat, b_lat;
    logic [WIDTH-1:0] next_sum;
    logic [7:0]       slice_sum;
    logic             slice_cout, slice_of;
    logic             last;
`ifdef SEQ_ADDSUB_CMP_EN
    logic             sub_lat;
`endif

    assign last = (idx == LAST_IDX);

    rca_8_overflow u_slice (
        .a        (a_lat[8*idx +: 8]),
        .b        (b_lat[8*idx +: 8]),
        .cin      (carry_q),
        .sum      (slice_sum),
        .cout     (slice_cout),
        .overflow (slice_of)
    );

    // Full result as it will stand after this pass; the compare flags need it on the last pass.
    always_comb begin
        next_sum              = sum;
        next_sum[8*idx +: 8]  = slice_sum;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                busy = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_lat     <= '0;
            b_lat     <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
`ifdef SEQ_ADDSUB_CMP_EN
            sub_lat      <= 1'b0;
            is_not_equal <= 1'b0;
            is_less_than <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_lat   <= a;
                        b_lat   <= sub ? ~b : b;
                        carry_q <= sub;
                        idx     <= '0;
`ifdef SEQ_ADDSUB_CMP_EN
                        sub_lat <= sub;
`endif
                    end
                end
                RUN: begin
                    sum     <= next_sum;
                    carry_q <= slice_cout;
                    if (last) begin
                        cout      <= slice_cout;
                        overflow  <= slice_of;
                        out_valid <= 1'b1;
`ifdef SEQ_ADDSUB_CMP_EN
                        is_not_equal <= sub_lat & (|next_sum);
                        is_less_than <= sub_lat & (next_sum[WIDTH-1] ^ slice_of);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_addsub_ctrl.sv
// Scoreboarded random + directed bench for seq_addsub_ctrl (WIDTH=32).
module tb_seq_addsub_ctrl;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset, in_valid, in_ready, sub, out_valid, out_ready;
    logic         cout, overflow, busy;
    logic [W-1:0] a, b, sum;
`ifdef SEQ_ADDSUB_CMP_EN
    logic         is_not_equal, is_less_than;
`endif

    seq_addsub_ctrl #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow),
`ifdef SEQ_ADDSUB_CMP_EN
        .is_not_equal(is_not_equal), .is_less_than(is_less_than),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         ne;
        logic         lt;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t   e;
        longint sx, sy, r;
        longint ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        if (s) begin
            e.sum  = x - y;
            e.cout = (ux >= uy);
            r      = sx - sy;
            e.ne   = (x != y);
            e.lt   = (sx < sy);
        end else begin
            e.sum  = x + y;
            e.cout = ((ux + uy) >= 64'sh1_0000_0000);
            r      = sx + sy;
            e.ne   = 1'b0;
            e.lt   = 1'b0;
        end
        e.ovf = (r > 64'sh7FFF_FFFF) || (r < -64'sh8000_0000);
        return e;
    endfunction

    // Monitor: compares every completed output handshake against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sum", sum, e.sum);
                    chk("cout", cout, e.cout);
                    chk("overflow", overflow, e.ovf);
`ifdef SEQ_ADDSUB_CMP_EN
                    chk("is_not_equal", is_not_equal, e.ne);
                    chk("is_less_than", is_less_than, e.lt);
`endif
                end
            end
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int hold);
        int           n;
        logic [W-1:0] s0;
        logic         c0, o0;
        @(negedge clock);
        a = x; b = y; sub = s; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        q.push_back(model(x, y, s));
        @(posedge clock);
        #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("latency", n, 4);
        if (!out_valid) return;
        chk("busy_done", {busy, in_ready}, 2'b10);
        s0 = sum; c0 = cout; o0 = overflow;
        repeat (hold) begin
            @(posedge clock);
            #1;
            chk("hold_stable", {out_valid, in_ready, c0 ^ cout, o0 ^ overflow, s0 ^ sum},
                {1'b1, 1'b0, 1'b0, 1'b0, 32'b0});
            in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("idle_after", {in_ready, busy, out_valid}, 3'b100);
    endtask

    initial begin
        int           n;
        logic [W-1:0] x, y;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", {in_ready, busy, out_valid, cout, overflow, sum},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'b0});
        reset = 1'b0;

        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5);

        // Reset mid-operation at idx=2: the operation is dropped.
        @(negedge clock);
        a = 32'h0101_0101; b = 32'h0101_0101; sub = 1'b0; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_in_run", {in_ready, busy, out_valid, sum}, {1'b1, 1'b0, 1'b0, 32'b0});

        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0);
        do_op(32'd5, 32'd7, 1'b1, 0);
        do_op(32'd7, 32'd7, 1'b1, 0);
        do_op(32'h8000_0000, 32'd1, 1'b1, 2);
        do_op(32'd5, 32'd7, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            if ($urandom_range(0, 3) == 0) x[31:28] = $urandom_range(0, 1) ? 4'h7 : 4'h8;
            y = ($urandom_range(0, 4) == 0) ? x : $urandom;
            do_op(x, y, 1'($urandom), $urandom_range(0, 3));
        end

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        chk("drain", q.size(), 0);
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
